// File: rtl/adder_multi_axil.sv
// rtl/adder_multi_axil.sv - multi-channel AXI4-Lite adder peripheral with start/done handshake
// Optional feature macro: ADDER_SAT_EN (clamp RESULT to all-ones on carry).
module adder_multi_axil #(
    parameter int NUM_CH      = 4,
    parameter int OP_WIDTH    = 32,
    parameter int PIPE_STAGES = 2,
    parameter int ADDR_WIDTH  = 7
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  irq
);
    localparam int          IW       = ADDR_WIDTH - 4;
    localparam logic [31:0] OP_MASK  = 32'hFFFF_FFFF >> (32 - OP_WIDTH);
    localparam logic [1:0]  CNT_LOAD = 2'(PIPE_STAGES - 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      state_q [NUM_CH];
    state_t      state_d [NUM_CH];
    logic [31:0] a_q [NUM_CH], a_d [NUM_CH];
    logic [31:0] b_q [NUM_CH], b_d [NUM_CH];
    logic [31:0] result_q [NUM_CH], result_d [NUM_CH];
    logic [31:0] sum_q [NUM_CH], sum_d [NUM_CH];
    logic [1:0]  cnt_q [NUM_CH], cnt_d [NUM_CH];
    logic [NUM_CH-1:0] acc_q, acc_d, ie_q, ie_d, done_q, done_d;
    logic [NUM_CH-1:0] carry_q, carry_d, sumc_q, sumc_d;

    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;

    logic          wr_hs, rd_hs, wr_ch_hit, wr_st_hit, rd_ok;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [1:0]    wr_off, rd_off;
    logic [31:0]   rd_word, status_w, op1;
    logic [32:0]   sum_full;
    logic          unused_addr_bits;

    assign wr_idx    = S_AXI_AWADDR[ADDR_WIDTH-1:4];
    assign wr_off    = S_AXI_AWADDR[3:2];
    assign rd_idx    = S_AXI_ARADDR[ADDR_WIDTH-1:4];
    assign rd_off    = S_AXI_ARADDR[3:2];
    assign wr_ch_hit = wr_idx < IW'(NUM_CH);
    assign wr_st_hit = (wr_idx == IW'(NUM_CH)) && (wr_off == 2'd0);
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Ready is combinational so the address and data beats are taken in one cycle.
    assign wr_hs = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !ARESET;
    assign rd_hs = S_AXI_ARVALID && !rvalid_q && !ARESET;

    assign S_AXI_AWREADY = wr_hs;
    assign S_AXI_WREADY  = wr_hs;
    assign S_AXI_ARREADY = rd_hs;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r & OP_MASK;
    endfunction

    always_comb begin
        rd_word  = '0;
        rd_ok    = 1'b0;
        status_w = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            status_w[ch]      = done_q[ch];
            status_w[8 + ch]  = (state_q[ch] == ST_BUSY);
            status_w[16 + ch] = carry_q[ch];
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rd_idx < IW'(NUM_CH) && rd_idx == IW'(ch)) begin
                rd_ok = 1'b1;
                case (rd_off)
                    2'd0:    rd_word = a_q[ch];
                    2'd1:    rd_word = b_q[ch];
                    2'd2:    rd_word = {29'd0, ie_q[ch], acc_q[ch], 1'b0};
                    default: rd_word = result_q[ch];
                endcase
            end
        end
        if (rd_idx == IW'(NUM_CH) && rd_off == 2'd0) begin
            rd_ok   = 1'b1;
            rd_word = status_w;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ie_d     = ie_q;
        done_d   = done_q;
        carry_d  = carry_q;
        sumc_d   = sumc_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        op1      = '0;
        sum_full = '0;

        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = rd_ok ? 2'b00 : 2'b10;
        end

        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = (wr_ch_hit || wr_st_hit) ? 2'b00 : 2'b10;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wr_ch_hit && wr_idx == IW'(ch)) begin
                    case (wr_off)
                        2'd0: a_d[ch] = merge_bytes(a_q[ch], S_AXI_WDATA, S_AXI_WSTRB);
                        2'd1: b_d[ch] = merge_bytes(b_q[ch], S_AXI_WDATA, S_AXI_WSTRB);
                        2'd2: if (S_AXI_WSTRB[0]) begin
                            acc_d[ch] = S_AXI_WDATA[1];
                            ie_d[ch]  = S_AXI_WDATA[2];
                            // The operands are snapshotted here, so later A/B writes cannot disturb the add.
                            if (S_AXI_WDATA[0] && state_q[ch] == ST_IDLE) begin
                                op1         = S_AXI_WDATA[1] ? result_q[ch] : a_q[ch];
                                sum_full    = {1'b0, op1} + {1'b0, b_q[ch]};
                                sumc_d[ch]  = sum_full[OP_WIDTH];
                                sum_d[ch]   = sum_full[31:0] & OP_MASK;
`ifdef ADDER_SAT_EN
                                if (sum_full[OP_WIDTH]) sum_d[ch] = OP_MASK;
`endif
                                state_d[ch] = ST_BUSY;
                                cnt_d[ch]   = CNT_LOAD;
                                done_d[ch]  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end else if (wr_st_hit && S_AXI_WSTRB[0] && S_AXI_WDATA[ch]) begin
                    done_d[ch] = 1'b0;
                end
            end
        end

        // Completion comes after the W1C so a same-cycle completion leaves done set.
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (state_q[ch] == ST_BUSY) begin
                if (cnt_q[ch] == 2'd0) begin
                    state_d[ch]  = ST_IDLE;
                    result_d[ch] = sum_q[ch];
                    carry_d[ch]  = sumc_q[ch];
                    done_d[ch]   = 1'b1;
                end else begin
                    cnt_d[ch] = cnt_q[ch] - 2'd1;
                end
            end
        end
    end

    always_comb begin
        irq = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) irq = irq | (done_q[ch] & ie_q[ch]);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rdata_q  <= '0;
            acc_q    <= '0;
            ie_q     <= '0;
            done_q   <= '0;
            carry_q  <= '0;
            sumc_q   <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch]  <= ST_IDLE;
                a_q[ch]      <= '0;
                b_q[ch]      <= '0;
                result_q[ch] <= '0;
                sum_q[ch]    <= '0;
                cnt_q[ch]    <= '0;
            end
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            acc_q    <= acc_d;
            ie_q     <= ie_d;
            done_q   <= done_d;
            carry_q  <= carry_d;
            sumc_q   <= sumc_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch]  <= state_d[ch];
                a_q[ch]      <= a_d[ch];
                b_q[ch]      <= b_d[ch];
                result_q[ch] <= result_d[ch];
                sum_q[ch]    <= sum_d[ch];
                cnt_q[ch]    <= cnt_d[ch];
            end
        end
    end
endmodule
